// File: rtl/sid_pkg.sv
// sid_pkg: shared definitions for the SID register write path.
//   SID_LAST_WR_ADDR  highest writable register address; anything above is
//                     read-only (0x19-0x1C) or unused and gets dropped
//   SID_FC_LO/HI, SID_RES_FILT  filter register addresses
//   SID_DELAY_W       storage width of the delay field in a queued command
//   sid_wr_cmd_t      queued write command {addr, data, delay}
//   sid_wr_state_t    issue FSM states
package sid_pkg;

  localparam logic [4:0] SID_LAST_WR_ADDR = 5'h18;
  localparam logic [4:0] SID_FC_LO        = 5'h15;
  localparam logic [4:0] SID_FC_HI        = 5'h16;
  localparam logic [4:0] SID_RES_FILT     = 5'h17;

  // Queue storage width of the delay field; the writer's DELAY_W should not
  // exceed it.
  localparam int unsigned SID_DELAY_W = 16;

  typedef struct packed {
    logic [4:0]             addr;
    logic [7:0]             data;
    logic [SID_DELAY_W-1:0] delay;
  } sid_wr_cmd_t;

  typedef enum logic [1:0] {
    SID_IDLE  = 2'd0,
    SID_WAIT  = 2'd1,
    SID_ISSUE = 2'd2
  } sid_wr_state_t;

  function automatic logic sidWritable(input logic [4:0] addr);
    return addr <= SID_LAST_WR_ADDR;
  endfunction

endpackage

// File: rtl/sid_cmd_fifo.sv
// sid_cmd_fifo: synchronous FIFO of sid_wr_cmd_t.
//   clk, iRstN   clock, synchronous active-low reset (flushes contents)
//   iPush, iCmd  write request and command; ignored while full, even when a
//                pop happens in the same cycle
//   iPop, oCmd   read request and head entry (oCmd valid while !oEmpty)
//   oFull, oEmpty, oLevel  status; a pushed entry is visible the next cycle
module sid_cmd_fifo
  import sid_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   iRstN,
  input  logic                   iPush,
  input  sid_wr_cmd_t            iCmd,
  input  logic                   iPop,
  output sid_wr_cmd_t            oCmd,
  output logic                   oFull,
  output logic                   oEmpty,
  output logic [$clog2(DEPTH):0] oLevel
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  sid_wr_cmd_t   mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [AW:0]   level;
  logic          doPush;
  logic          doPop;

  assign oFull  = (level == FULL_LEVEL);
  assign oEmpty = (level == '0);
  assign oLevel = level;
  assign doPush = iPush & ~oFull;
  assign doPop  = iPop & ~oEmpty;
  assign oCmd   = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (!iRstN) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= iCmd;
  end

endmodule

// File: rtl/sid_reg_writer.sv
// sid_reg_writer: timed write initiator for the SID register bus.
// Commands {addr, data, delay} arrive on a valid/ready stream, are queued,
// and each is issued after `delay` iClkEn ticks. Writes to addresses above
// 0x18 are dropped (oDropped pulse) instead of strobing oWE.
//   clk, iRstN     clock, synchronous active-low reset
//   iClkEn         SID clock enable; only these cycles count down a delay
//   iValid/oReady  command handshake; iCmdAddr/iCmdData/iCmdDelay payload
//   oWE/oAddr/oData  register bus; oAddr/oData hold the last issued write
//   oDropped       one-cycle pulse for a read-only/unused target
//   oLevel, oBusy  queue occupancy, activity indicator
// Optional (macro SID_SHADOW_READBACK_EN): iRdAddr/oRdData registered
// readback of a shadow copy of every writable register.
module sid_reg_writer
  import sid_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned DELAY_W = 16
) (
  input  logic                   clk,
  input  logic                   iRstN,
  input  logic                   iClkEn,
  input  logic                   iValid,
  output logic                   oReady,
  input  logic [4:0]             iCmdAddr,
  input  logic [7:0]             iCmdData,
  input  logic [DELAY_W-1:0]     iCmdDelay,
  output logic                   oWE,
  output logic [4:0]             oAddr,
  output logic [7:0]             oData,
  output logic                   oDropped,
  output logic [$clog2(DEPTH):0] oLevel,
  output logic                   oBusy
`ifdef SID_SHADOW_READBACK_EN
  ,
  input  logic [4:0]             iRdAddr,
  output logic [7:0]             oRdData
`endif
);

  sid_wr_state_t      state;
  sid_wr_state_t      stateNext;
  sid_wr_cmd_t        pushCmd;
  sid_wr_cmd_t        headCmd;
  logic               fifoFull;
  logic               fifoEmpty;
  logic               pop;
  logic [DELAY_W-1:0] headDelay;
  logic [DELAY_W-1:0] cnt;
  logic [4:0]         cmdAddr;
  logic [7:0]         cmdData;
  logic [4:0]         lastAddr;
  logic [7:0]         lastData;
  logic               issueWr;

  always_comb begin
    pushCmd       = '0;
    pushCmd.addr  = iCmdAddr;
    pushCmd.data  = iCmdData;
    pushCmd.delay = SID_DELAY_W'(iCmdDelay);
  end

  sid_cmd_fifo #(.DEPTH(DEPTH)) cmdFifo (
    .clk    (clk),
    .iRstN  (iRstN),
    .iPush  (iValid),
    .iCmd   (pushCmd),
    .iPop   (pop),
    .oCmd   (headCmd),
    .oFull  (fifoFull),
    .oEmpty (fifoEmpty),
    .oLevel (oLevel)
  );

  assign headDelay = headCmd.delay[DELAY_W-1:0];

  always_comb begin
    stateNext = state;
    pop       = 1'b0;
    case (state)
      SID_IDLE: begin
        if (!fifoEmpty) begin
          pop       = 1'b1;
          stateNext = (headDelay != '0) ? SID_WAIT : SID_ISSUE;
        end
      end
      SID_WAIT: begin
        if (iClkEn && cnt == DELAY_W'(1)) stateNext = SID_ISSUE;
      end
      SID_ISSUE: stateNext = SID_IDLE;
      default:   stateNext = SID_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!iRstN) begin
      state    <= SID_IDLE;
      cnt      <= '0;
      cmdAddr  <= '0;
      cmdData  <= '0;
      lastAddr <= '0;
      lastData <= '0;
    end else begin
      state <= stateNext;
      if (pop) begin
        cnt     <= headDelay;
        cmdAddr <= headCmd.addr;
        cmdData <= headCmd.data;
      end else if (state == SID_WAIT && iClkEn && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (issueWr) begin
        lastAddr <= cmdAddr;
        lastData <= cmdData;
      end
    end
  end

  // Strobes are gated by reset so a state left over from before the reset
  // edge can never reach the bus.
  assign issueWr  = iRstN & (state == SID_ISSUE) & sidWritable(cmdAddr);
  assign oWE      = issueWr;
  assign oDropped = iRstN & (state == SID_ISSUE) & ~sidWritable(cmdAddr);
  // The bus shows the latched command only during its strobe; otherwise it
  // holds the previous write so a queued command never leaks onto it early.
  assign oAddr    = issueWr ? cmdAddr : lastAddr;
  assign oData    = issueWr ? cmdData : lastData;
  assign oReady   = ~fifoFull;
  assign oBusy    = (state != SID_IDLE) | (oLevel != '0);

`ifdef SID_SHADOW_READBACK_EN
  logic [7:0] shadow [32];

  always_ff @(posedge clk) begin
    if (!iRstN) begin
      for (int unsigned i = 0; i < 32; i++) shadow[i] <= '0;
      oRdData <= '0;
    end else begin
      if (issueWr) shadow[cmdAddr] <= cmdData;
      if (!sidWritable(iRdAddr))                 oRdData <= '0;
      else if (issueWr && iRdAddr == cmdAddr)    oRdData <= cmdData;
      else                                       oRdData <= shadow[iRdAddr];
    end
  end
`endif

endmodule
